// File: rtl/sn185_seq_bin2bcd.sv
// sn185_seq_bin2bcd: sequential binary-to-BCD converter.
// Converts a BIN_W-bit unsigned value to DIGITS packed BCD digits with
// the shift-and-add-3 (double dabble) method, one input bit per clock.
// A start/busy/done handshake frames each conversion. The active-low
// enable g_n blanks the held result to all ones without touching the
// conversion itself.
module sn185_seq_bin2bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  g_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Apply the +3 correction to every digit that is 5 or more. Each digit
    // is corrected independently; nothing carries between digits here.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        logic [3:0]       dig;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = acc[4*i +: 4];
            if (dig >= 4'd5) begin
                res[4*i +: 4] = dig + 4'd3;
            end else begin
                res[4*i +: 4] = dig;
            end
        end
        return res;
    endfunction

    state_t              state_q,   state_d;
    logic [BIN_W-1:0]    shift_q,   shift_d;
    logic [BCD_W-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]    result_q,  result_d;
    logic                ovf_q,     ovf_d;
    logic                done_q,    done_d;
    logic                busy_q,    busy_d;

    logic [BCD_W-1:0]    adj_s;
    logic [BCD_W-1:0]    acc_shift_s;
    logic [BIN_W-1:0]    shift_shift_s;
    logic                carry_s;

    // One double-dabble step: correct digits, then shift {acc, shift} left.
    // The bit leaving the top digit is the carry into a digit we do not
    // keep, so it marks the value as too large for DIGITS digits.
    always_comb begin
        adj_s         = add3_digits(acc_q);
        carry_s       = adj_s[BCD_W-1];
        acc_shift_s   = {adj_s[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_shift_s = {shift_q[BIN_W-2:0], 1'b0};
    end

    // Next-state and handshake logic for the IDLE/CONV controller.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end else begin
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_CONV: begin
                shift_d   = shift_shift_s;
                acc_d     = acc_shift_s;
                ovf_acc_d = ovf_acc_q | carry_s;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = acc_shift_s;
                    ovf_d    = ovf_acc_q | carry_s;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    busy_d   = 1'b1;
                    state_d  = S_CONV;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Output drive; g_n blanks the held result combinationally.
    always_comb begin
        busy = busy_q;
        done = done_q;
        ovf  = ovf_q;
        if (g_n) begin
            bcd_out = {BCD_W{1'b1}};
        end else begin
            bcd_out = result_q;
        end
    end

endmodule

// File: tb/tb_sn185_seq_bin2bcd.sv
// Testbench for sn185_seq_bin2bcd: a 3-digit and a 2-digit instance share
// start/bin_in/g_n/rst_n. The driver pushes expected results, computed
// with plain decimal arithmetic, into per-instance queues; a monitor pops
// and compares on every done pulse and checks the held outputs each cycle.
module tb_sn185_seq_bin2bcd;

    localparam int BIN_W = 8;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        g_n;
    logic        start;
    logic [7:0]  bin_in;

    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q3[$];
    exp_t q2[$];

    sn185_seq_bin2bcd #(.BIN_W(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .g_n(g_n), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .ovf(ovf3), .bcd_out(bcd3)
    );

    sn185_seq_bin2bcd #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .g_n(g_n), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .ovf(ovf2), .bcd_out(bcd2)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal digits of v, low digit first, by repeated division by ten.
    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r;
        int          x;
        r = 12'h000;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Drive one accepted start at the current negedge; record expectations.
    task automatic accept(input int v);
        exp_t e;
        bin_in = 8'(v);
        start  = 1'b1;
        e.cyc  = cyc + 1 + BIN_W;
        e.bcd  = ref_bcd(v, 3);
        e.ovf  = (v > 999);
        q3.push_back(e);
        e.bcd  = ref_bcd(v, 2);
        e.ovf  = (v > 99);
        q2.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'($urandom);
        chk("busy_after_accept", {31'd0, busy3}, 32'd1);
    endtask

    // Return at the negedge where done is high, bounded by a cycle budget.
    task automatic wait_done;
        int i;
        for (i = 0; i < 40; i++) begin
            if (done3) break;
            @(negedge clk);
        end
        if (i == 40) chk("done_timeout", {31'd0, done3}, 32'd1);
    endtask

    // Monitor: pop on done, check latency/result, and check held outputs.
    initial begin
        logic [11:0] last3, last2;
        logic        lov3, lov2;
        exp_t        e;
        last3 = 12'h000; last2 = 12'h000; lov3 = 1'b0; lov2 = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                last3 = 12'h000; last2 = 12'h000; lov3 = 1'b0; lov2 = 1'b0;
            end else begin
                if (done3) begin
                    if (q3.size() == 0) begin
                        chk("unexpected_done3", q3.size(), 32'd1);
                    end else begin
                        e = q3.pop_front();
                        chk("done_latency", cyc, e.cyc);
                        last3 = e.bcd;
                        lov3  = e.ovf;
                    end
                end
                if (done2) begin
                    if (q2.size() == 0) begin
                        chk("unexpected_done2", q2.size(), 32'd1);
                    end else begin
                        e = q2.pop_front();
                        last2 = e.bcd;
                        lov2  = e.ovf;
                    end
                end
                chk("bcd3", {20'd0, bcd3}, g_n ? 32'hFFF : {20'd0, last3});
                chk("ovf3", {31'd0, ovf3}, {31'd0, lov3});
                chk("bcd2", {24'd0, bcd2}, g_n ? 32'hFF : {24'd0, last2[7:0]});
                chk("ovf2", {31'd0, ovf2}, {31'd0, lov2});
                chk("done_match", {31'd0, done2}, {31'd0, done3});
            end
        end
    end

    // Directed scenarios followed by randomized conversions.
    initial begin
        int dir_vals[3] = '{255, 63, 9};
        int ovf_vals[3] = '{100, 99, 255};
        int v;
        int gap;
        rst_n  = 1'b0;
        g_n    = 1'b0;
        start  = 1'b0;
        bin_in = 8'h00;
        #3;
        chk("rst_busy", {31'd0, busy3}, 32'd0);
        chk("rst_done", {31'd0, done3}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf3},  32'd0);
        chk("rst_bcd",  {20'd0, bcd3},  32'h000);
        g_n = 1'b1;
        #1;
        chk("rst_bcd_gn", {20'd0, bcd3}, 32'hFFF);
        g_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero, then ordinary values.
        accept(0);
        wait_done();
        @(negedge clk);
        foreach (dir_vals[i]) begin
            accept(dir_vals[i]);
            wait_done();
            @(negedge clk);
        end

        // Starts during a conversion are ignored; start during done accepted.
        accept(200);
        @(negedge clk);
        start = 1'b1; bin_in = 8'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; bin_in = 8'd17;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        accept(17);
        wait_done();
        @(negedge clk);

        // Output enable gating.
        accept(255);
        wait_done();
        @(negedge clk);
        g_n = 1'b1;
        #1;
        chk("gn_blank", {20'd0, bcd3}, 32'hFFF);
        chk("gn_busy",  {31'd0, busy3}, 32'd0);
        accept(42);
        wait_done();
        @(negedge clk);
        g_n = 1'b0;
        #1;
        chk("gn_release", {20'd0, bcd3}, 32'h042);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        accept(99);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy3}, 32'd0);
        chk("arst_done", {31'd0, done3}, 32'd0);
        chk("arst_ovf",  {31'd0, ovf3},  32'd0);
        chk("arst_bcd",  {20'd0, bcd3},  32'h000);
        chk("arst_bcd2", {24'd0, bcd2},  32'h00);
        q3.delete();
        q2.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        accept(99);
        wait_done();
        @(negedge clk);

        // Overflow on the 2-digit instance.
        foreach (ovf_vals[i]) begin
            accept(ovf_vals[i]);
            wait_done();
            @(negedge clk);
        end

        // Randomized conversions, random gaps, occasional blanking.
        for (int n = 0; n < 80; n++) begin
            v   = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2));
            g_n = ($urandom_range(0, 4) == 0);
            accept(v);
            wait_done();
            if (gap > 0) repeat (gap) @(negedge clk);
        end
        g_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue3_empty", q3.size(), 32'd0);
        chk("queue2_empty", q2.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
